ov5640_capture_ctrl: RTL and testbench

//  Capture sequencer for the OV5640 DVP pixel path, in the ov5640_pclk domain between sensor pins and the write FIFO.

---
 rtl/ov5640_capture_ctrl.sv | 140 ++++++++++++++
 tb/tb_ov5640_capture_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_capture_ctrl.sv
// OV5640 DVP capture sequencer: frame skip, byte-pair packing, whole-frame write gating, geometry checks.
// Optional OV5640_CAP_ERRCNT_EN adds a saturating err_cnt[7:0] of line_err pulses.
module ov5640_capture_ctrl #(
  parameter int SKIP_FRAMES = 10,
  parameter int H_PIX       = 1280,
  parameter int V_LINES     = 720
) (
  input  logic        ov5640_pclk,
  input  logic        s_rst,
  input  logic        cfg_done,
  input  logic        cap_start,
  input  logic        cap_stop,
  input  logic        cap_mode,
  input  logic        ov5640_href,
  input  logic        ov5640_vsync,
  input  logic [7:0]  ov5640_data,
  output logic [15:0] m_data,
  output logic        m_wr_en,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err,
  output logic        busy
`ifdef OV5640_CAP_ERRCNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam int SW = $clog2(SKIP_FRAMES) + 1;
  localparam int PW = $clog2(H_PIX) + 1;
  localparam int LW = $clog2(V_LINES) + 1;

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_e;

  state_e        state, state_nxt;
  logic          vs_r, href_r, phase, mode_r, stop_pend;
  logic [SW-1:0] skip_cnt;
  logic [PW-1:0] pix_cnt, pix_inc;
  logic [LW-1:0] line_cnt, line_inc;
  logic          vs_pos, href_fall;
  logic          fs_nxt, fd_nxt, le_nxt, skip_adv, frame_end, start_acc;

  assign vs_pos    = ov5640_vsync & ~vs_r;
  assign href_fall = ~ov5640_href & href_r;
  assign busy      = (state != IDLE);
  assign start_acc = (state == IDLE) && (state_nxt == SYNC);

  // Saturating views that include the write / line ending in this same cycle.
  assign pix_inc  = (m_wr_en && pix_cnt != '1) ? pix_cnt + PW'(1) : pix_cnt;
  assign line_inc = (href_fall && line_cnt != '1) ? line_cnt + LW'(1) : line_cnt;

  always_ff @(posedge ov5640_pclk) begin
    if (s_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fs_nxt    = 1'b0;
    fd_nxt    = 1'b0;
    le_nxt    = 1'b0;
    skip_adv  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: if (cap_start && cfg_done) state_nxt = SYNC;
      SYNC: begin
        if (!cfg_done || cap_stop) state_nxt = IDLE;
        else if (vs_pos) begin
          if (skip_cnt == SW'(SKIP_FRAMES)) begin
            state_nxt = CAPTURE;
            fs_nxt    = 1'b1;
          end else skip_adv = 1'b1;
        end
      end
      CAPTURE: begin
        if (!cfg_done) state_nxt = IDLE;
        else begin
          if (href_fall && pix_inc != PW'(H_PIX)) le_nxt = 1'b1;
          if (vs_pos) begin
            fd_nxt    = 1'b1;
            frame_end = 1'b1;
            if (line_inc != LW'(V_LINES)) le_nxt = 1'b1;
            if (!mode_r || stop_pend || cap_stop) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ov5640_pclk) begin
    if (s_rst) begin
      vs_r        <= 1'b0;
      href_r      <= 1'b0;
      phase       <= 1'b0;
      mode_r      <= 1'b0;
      stop_pend   <= 1'b0;
      skip_cnt    <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      m_data      <= '0;
      m_wr_en     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      vs_r        <= ov5640_vsync;
      href_r      <= ov5640_href;
      phase       <= ov5640_href ? ~phase : 1'b0;
      if (ov5640_href && !phase) m_data[15:8] <= ov5640_data;
      if (ov5640_href && phase)  m_data[7:0]  <= ov5640_data;
      m_wr_en     <= (state == CAPTURE) && ov5640_href && phase;
      frame_start <= fs_nxt;
      frame_done  <= fd_nxt;
      line_err    <= le_nxt;
      if (start_acc) begin
        mode_r   <= cap_mode;
        skip_cnt <= '0;
      end else if (skip_adv && skip_cnt != '1) skip_cnt <= skip_cnt + SW'(1);
      // Geometry counters only run inside a captured frame and restart at each boundary.
      if (state != CAPTURE || frame_end) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else begin
        pix_cnt  <= href_fall ? '0 : pix_inc;
        line_cnt <= line_inc;
      end
      if (state_nxt == IDLE)                  stop_pend <= 1'b0;
      else if (state == CAPTURE && cap_stop)  stop_pend <= 1'b1;
    end
  end

`ifdef OV5640_CAP_ERRCNT_EN
  always_ff @(posedge ov5640_pclk) begin
    if (s_rst || start_acc)           err_cnt <= '0;
    else if (le_nxt && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ov5640_capture_ctrl.sv
// Bench for ov5640_capture_ctrl with small frame geometry: table-driven scenarios plus
// hand-written corner sequences; pixels are checked through an expected queue.
module tb_ov5640_capture_ctrl;
  localparam int SKIP = 1;
  localparam int HP   = 4;
  localparam int VL   = 3;

  logic        clk = 1'b0;
  logic        s_rst, cfg_done, cap_start, cap_stop, cap_mode;
  logic        href, vsync;
  logic [7:0]  data;
  logic [15:0] m_data;
  logic        m_wr_en, frame_start, frame_done, line_err, busy;
`ifdef OV5640_CAP_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  ov5640_capture_ctrl #(.SKIP_FRAMES(SKIP), .H_PIX(HP), .V_LINES(VL)) dut (
    .ov5640_pclk(clk), .s_rst(s_rst), .cfg_done(cfg_done), .cap_start(cap_start),
    .cap_stop(cap_stop), .cap_mode(cap_mode), .ov5640_href(href), .ov5640_vsync(vsync),
    .ov5640_data(data), .m_data(m_data), .m_wr_en(m_wr_en), .frame_start(frame_start),
    .frame_done(frame_done), .line_err(line_err), .busy(busy)
`ifdef OV5640_CAP_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  typedef struct {
    bit cfg;
    bit mode;
    int nvs;
    int nlines;
    int short_ln;
    int stop_k;
    int exp_fs;
    int exp_fd;
    int exp_le;
    bit exp_busy;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] exp_q[$];
  int          n_chk = 0, n_pass = 0;
  int          n_fs, n_fd, n_le;
  bit          exp_cap, tb_phase;
  logic [7:0]  tb_hi;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // One clock of pin activity; expected pixels are queued as phase-1 bytes go out.
  task automatic cyc(input logic h, input logic v, input logic [7:0] d);
    href = h; vsync = v; data = d;
    if (h) begin
      if (tb_phase) begin
        if (exp_cap) exp_q.push_back({tb_hi, d});
        tb_phase = 1'b0;
      end else begin
        tb_hi    = d;
        tb_phase = 1'b1;
      end
    end else tb_phase = 1'b0;
    @(posedge clk); #1;
    cap_start = 1'b0;
    cap_stop  = 1'b0;
  endtask

  task automatic send_line(input int npix);
    for (int i = 0; i < 2 * npix; i++) cyc(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_vsync(input bit stop);
    cap_stop = stop;
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int nlines, input int short_ln, input bit stop);
    for (int l = 0; l < nlines; l++) begin
      if (stop && l == 1) cap_stop = 1'b1;
      send_line((l == short_ln) ? HP - 1 : HP);
    end
  endtask

  task automatic do_reset();
    s_rst = 1'b1; cfg_done = 1'b0; cap_start = 1'b0; cap_stop = 1'b0; cap_mode = 1'b0;
    exp_cap = 1'b0; exp_q.delete();
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    s_rst = 1'b0;
    n_fs = 0; n_fd = 0; n_le = 0;
  endtask

  task automatic start_cap(input bit cfg, input bit mode);
    cfg_done = cfg; cap_mode = mode; cap_start = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  function automatic bit cap_active(input int k, input vec_t v);
    if (!v.cfg || k < SKIP + 1) return 1'b0;
    if (k == SKIP + 1) return 1'b1;
    return v.mode && (v.stop_k == 0 || k <= v.stop_k);
  endfunction

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4, VL,     -1, 0, 1, 1, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4, VL,      1, 0, 1, 1, 1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 5, VL,     -1, 3, 1, 2, 0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4, VL,     -1, 0, 1, 2, 0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 3, VL,     -1, 0, 0, 0, 0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 4, VL - 1, -1, 0, 1, 1, 1, 1'b0};
    href = 1'b0; vsync = 1'b0; data = 8'h00; tb_phase = 1'b0; tb_hi = 8'h00;

    fork
      forever begin
        @(negedge clk);
        if (!s_rst) begin
          if (frame_start) n_fs++;
          if (frame_done)  n_fd++;
          if (line_err)    n_le++;
          if (m_wr_en) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              $display("FAIL wr_unexpected actual m_wr_en=1 m_data=%0h required m_wr_en=0", m_data);
            end else chk("pixel", 32'(m_data), 32'(exp_q.pop_front()));
          end
        end
      end
    join_none

    do_reset();
    chk("reset_outputs", 32'({m_data, m_wr_en, frame_start, frame_done, line_err, busy}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      start_cap(vecs[i].cfg, vecs[i].mode);
      for (int k = 1; k <= vecs[i].nvs; k++) begin
        send_vsync(1'b0);
        exp_cap = cap_active(k, vecs[i]);
        if (k < vecs[i].nvs) send_frame(vecs[i].nlines, vecs[i].short_ln, k == vecs[i].stop_k);
      end
      exp_cap = 1'b0;
      repeat (4) cyc(1'b0, 1'b0, 8'h00);
      chk($sformatf("v%0d_frame_start", i), 32'(n_fs), 32'(vecs[i].exp_fs));
      chk($sformatf("v%0d_frame_done", i), 32'(n_fd), 32'(vecs[i].exp_fd));
      chk($sformatf("v%0d_line_err", i), 32'(n_le), 32'(vecs[i].exp_le));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_queue_empty", i), 32'(exp_q.size()), 32'd0);
`ifdef OV5640_CAP_ERRCNT_EN
      chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_le));
`endif
    end

    // Exact byte packing and strobe timing for a single pair.
    do_reset();
    start_cap(1'b1, 1'b0);
    send_vsync(1'b0);
    send_vsync(1'b0);
    exp_cap = 1'b1;
    cyc(1'b1, 1'b0, 8'hA1);
    chk("t2_wr_after_a1", 32'(m_wr_en), 32'd0);
    cyc(1'b1, 1'b0, 8'hB2);
    chk("t2_wr_after_b2", 32'(m_wr_en), 32'd1);
    chk("t2_data", 32'(m_data), 32'h0000A1B2);
    cyc(1'b0, 1'b0, 8'h00);
    chk("t2_wr_after_href_low", 32'(m_wr_en), 32'd0);
    chk("t2_short_line_err", 32'(line_err), 32'd1);

    // Reset in the middle of a captured line.
    send_line(HP);
    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 8'h33);
    exp_cap = 1'b0;
    s_rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h44);
    exp_q.delete();
    chk("t5_reset_outputs", 32'({m_data, m_wr_en, frame_start, frame_done, line_err, busy}), 32'd0);
    s_rst = 1'b0;
    n_fs = 0; n_fd = 0; n_le = 0;
    cyc(1'b0, 1'b0, 8'h00);
    send_vsync(1'b0);
    send_line(HP);
    chk("t5_no_restart_busy", 32'(busy), 32'd0);

    // Losing cfg_done mid-frame abandons capture without frame_done.
    do_reset();
    start_cap(1'b1, 1'b1);
    send_vsync(1'b0);
    send_vsync(1'b0);
    exp_cap = 1'b1;
    send_line(HP);
    exp_cap = 1'b0;
    cfg_done = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    chk("cfg_drop_busy", 32'(busy), 32'd0);
    send_line(HP);
    send_vsync(1'b0);
    chk("cfg_drop_no_done", 32'(n_fd), 32'd0);

    // Stop coinciding with the closing frame boundary in continuous mode.
    do_reset();
    start_cap(1'b1, 1'b1);
    send_vsync(1'b0);
    send_vsync(1'b0);
    exp_cap = 1'b1;
    send_frame(VL, -1, 1'b0);
    exp_cap = 1'b0;
    send_vsync(1'b1);
    send_frame(VL, -1, 1'b0);
    send_vsync(1'b0);
    chk("t6_frame_done", 32'(n_fd), 32'd1);
    chk("t6_frame_start", 32'(n_fs), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
